simple_cpu_ctrl: RTL and testbench
==================================

Name: simple_cpu_ctrl

Overview:
Instruction register, decoder and control FSM that sequences the existing datapath through one Simple RISC instruction per start pulse. It is the initiator of the datapath control interface. It drives readnum/writenum, vsel, loada/loadb/loadc/loads, write, asel/bsel, shift, ALUop, sximm8 and imm5, and it reports completion on w. It sits between instruction fetch (or a test harness) and the datapath.

Parameters:
IR_RESET, 16'h0000, value loaded into the instruction register on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; forces state WAIT and IR=IR_RESET
s  input  1  start: begin executing the IR contents
load  input  1  capture in into the IR
in  input  16  instruction word
w  output  1  1 when idle in WAIT and ready for the next s
readnum  output  3  datapath register-file read address
writenum  output  3  datapath register-file write address
write  output  1  register-file write enable
vsel  output  2  writeback select: 00 C, 01 PC, 10 IMM, 11 MDATA
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status register
asel  output  1  1 forces the ALU A input to 0
bsel  output  1  1 selects the immediate on the ALU B input
shift  output  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1
ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 MVN
sximm8  output  16  sign-extended IR[7:0]
imm5  output  5  IR[4:0]

Behaviour:
- Encoding:
  - opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
  - 110/10 is MOV Rn,#imm8.
  - 110/00 is MOV Rd,Rm{,sh}.
  - 101/op is ALU: op 00 ADD, 01 CMP, 10 AND, 11 MVN Rd,Rm{,sh}.
  - Any other opcode/op is illegal.
- IR: load=1 in state WAIT captures in at the edge. load is ignored outside WAIT. load and s together capture the new word, and DECODE uses it.
- FSM states and transitions:
  - WAIT: go to DECODE on s.
  - DECODE:
    - MOV imm goes to WRITE_IMM.
    - MOV reg and MVN go to GET_B.
    - ADD/CMP/AND go to GET_A.
    - Illegal goes to WAIT; no write, no load.
  - GET_A: goes to GET_B.
  - GET_B: goes to ALU.
  - ALU: CMP goes to WAIT; everything else goes to WRITE_REG.
  - WRITE_REG: goes to WAIT.
  - WRITE_IMM: goes to WAIT.
- Moore outputs, decoded combinationally from state and IR. Every load/write strobe is 0 outside its own state:
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU:
    - loadc=1, bsel=0, shift=sh.
    - asel=1 for MOV reg and MVN, else 0.
    - ALUop=ADD for MOV reg, else op.
    - loads=1 for ALU-class instructions, 0 for MOV reg.
  - WRITE_REG: writenum=Rd, vsel=00, write=1.
  - WRITE_IMM: writenum=Rn, vsel=10, write=1.
- w=1 only in WAIT.
- sximm8 and imm5 are continuous functions of the IR.
- Outside the listed states, readnum, writenum, vsel, shift, ALUop, asel and bsel are all 0.
- Latency, counted in edges after the edge that samples s:
  - MOV imm: write in cycle 2, w=1 in cycle 3.
  - ADD/AND: write in cycle 5, w=1 in cycle 6.
  - CMP: loads in cycle 4, w=1 in cycle 5, no write.
  - MOV reg/MVN: write in cycle 4, w=1 in cycle 5.
- s while busy is ignored.
- reset mid-instruction: next state WAIT, IR=IR_RESET, all strobes 0 in that same cycle, no partial write afterwards.
- No illegal-state lockup: unused state encodings go to WAIT.

Decomposition:
- cpu_defs_pkg:
  - state enum
  - opcode/op constants
  - VSEL_C/PC/IMM/MDATA
  - ALU_ADD/SUB/AND/MVN
  - SH_NONE/L1/R1/RX
  - register-index constants shared with the datapath bench
- Sub-module instr_decoder: combinational field extraction, sign extension, instruction-class flags (is_mov_imm, is_mov_reg, is_alu, is_cmp, illegal).

Test Plan:
- Reset, then load 0xD032 (MOV R0,#50) with s pulse -> w falls next cycle; write=1, writenum=0, vsel=10, sximm8=0x0032 in cycle 2; w=1 in cycle 3.
- IR=0xA041 (ADD R2,R0,R1) -> readnum 0 with loada, then readnum 1 with loadb; loadc=loads=1 with ALUop=00; then write=1 to writenum=2, vsel=00; w back in cycle 6.
- IR=0xA801 (CMP R0,R1) -> loads=1 with ALUop=01 in cycle 4; write never asserted; w=1 in cycle 5.
- IR=0xB8E7 (MVN R7,R7) and 0xC069 (MOV R3,R1,LSL#1) -> no GET_A; asel=1; ALUop 11 then 00; shift 00 then 01; writenum 7 then 3.
- IR=0xD0FF -> sximm8=0xFFFF. Illegal 0xE000 -> DECODE then WAIT with no strobes. s or load while busy -> IR unchanged, no restart.
- reset asserted in GET_B of an ADD -> WAIT next edge; write stays 0 for the following 6 cycles; w=1.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the Simple RISC controller: FSM states, opcode
// fields, datapath select codes and register indices.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_L1   = 2'b01;
  localparam logic [1:0] SH_R1   = 2'b10;
  localparam logic [1:0] SH_RX   = 2'b11;

  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;
  localparam logic [2:0] REG_R4 = 3'd4;
  localparam logic [2:0] REG_R5 = 3'd5;
  localparam logic [2:0] REG_R6 = 3'd6;
  localparam logic [2:0] REG_R7 = 3'd7;

  function automatic logic [15:0] sign_ext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/simple_cpu_ctrl_if.sv
// Datapath control bundle driven by the controller (master) and consumed
// by the datapath (slave).
interface simple_cpu_ctrl_if;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [4:0]  imm5;

  modport master (
    output readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, imm5
  );

  modport slave (
    input readnum, writenum, write, vsel, loada, loadb, loadc, loads,
          asel, bsel, shift, ALUop, sximm8, imm5
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational field extraction and instruction classification for the
// Simple RISC encoding held in the instruction register.
module instr_decoder
  import cpu_defs_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [1:0]  op,
  output logic [15:0] sximm8,
  output logic [4:0]  imm5,
  output logic        is_mov_imm,
  output logic        is_mov_reg,
  output logic        is_alu,
  output logic        is_cmp,
  output logic        is_mvn,
  output logic        illegal
);

  logic [2:0] opcode_s;

  assign opcode_s = ir[15:13];
  assign op       = ir[12:11];
  assign rn       = ir[10:8];
  assign rd       = ir[7:5];
  assign sh       = ir[4:3];
  assign rm       = ir[2:0];
  assign sximm8   = sign_ext8(ir[7:0]);
  assign imm5     = ir[4:0];

  assign is_mov_imm = (opcode_s == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode_s == OPC_MOV) && (op == OP_MOV_REG);
  assign is_alu     = (opcode_s == OPC_ALU);
  assign is_cmp     = is_alu && (op == OP_CMP);
  assign is_mvn     = is_alu && (op == OP_MVN);
  assign illegal    = !(is_mov_imm || is_mov_reg || is_alu);

endmodule

// File: rtl/simple_cpu_ctrl.sv
// Instruction register plus Moore control FSM that steps the datapath
// through one Simple RISC instruction per start pulse.
module simple_cpu_ctrl
  import cpu_defs_pkg::*;
#(
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic               load,
  input  logic [15:0]        in,
  output logic               w,
  simple_cpu_ctrl_if.master  dp
);

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] ir_r;

  logic [2:0]  rn_s, rd_s, rm_s;
  logic [1:0]  sh_s, op_s;
  logic [15:0] sximm8_s;
  logic [4:0]  imm5_s;
  logic        is_mov_imm_s, is_mov_reg_s, is_alu_s, is_cmp_s, is_mvn_s, illegal_s;

  instr_decoder u_dec (
    .ir         (ir_r),
    .rn         (rn_s),
    .rd         (rd_s),
    .rm         (rm_s),
    .sh         (sh_s),
    .op         (op_s),
    .sximm8     (sximm8_s),
    .imm5       (imm5_s),
    .is_mov_imm (is_mov_imm_s),
    .is_mov_reg (is_mov_reg_s),
    .is_alu     (is_alu_s),
    .is_cmp     (is_cmp_s),
    .is_mvn     (is_mvn_s),
    .illegal    (illegal_s)
  );

  // State register and instruction register; IR only accepts words while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_WAIT;
      ir_r    <= IR_RESET;
    end else begin
      state_r <= next_state_s;
      if ((state_r == S_WAIT) && load) begin
        ir_r <= in;
      end else begin
        ir_r <= ir_r;
      end
    end
  end

  // Next-state logic; any unused encoding falls back to WAIT
  always_comb begin
    next_state_s = S_WAIT;
    case (state_r)
      S_WAIT: begin
        if (s) next_state_s = S_DECODE;
        else   next_state_s = S_WAIT;
      end
      S_DECODE: begin
        if (illegal_s)                       next_state_s = S_WAIT;
        else if (is_mov_imm_s)               next_state_s = S_WRITE_IMM;
        else if (is_mov_reg_s || is_mvn_s)   next_state_s = S_GET_B;
        else if (is_alu_s)                   next_state_s = S_GET_A;
        else                                 next_state_s = S_WAIT;
      end
      S_GET_A:     next_state_s = S_GET_B;
      S_GET_B:     next_state_s = S_ALU;
      S_ALU: begin
        if (is_cmp_s) next_state_s = S_WAIT;
        else          next_state_s = S_WRITE_REG;
      end
      S_WRITE_REG: next_state_s = S_WAIT;
      S_WRITE_IMM: next_state_s = S_WAIT;
      default:     next_state_s = S_WAIT;
    endcase
  end

  // Moore outputs; reset suppresses every strobe in the cycle it is asserted
  always_comb begin
    w           = (state_r == S_WAIT);
    dp.readnum  = 3'd0;
    dp.writenum = 3'd0;
    dp.write    = 1'b0;
    dp.vsel     = VSEL_C;
    dp.loada    = 1'b0;
    dp.loadb    = 1'b0;
    dp.loadc    = 1'b0;
    dp.loads    = 1'b0;
    dp.asel     = 1'b0;
    dp.bsel     = 1'b0;
    dp.shift    = SH_NONE;
    dp.ALUop    = ALU_ADD;
    dp.sximm8   = sximm8_s;
    dp.imm5     = imm5_s;
    if (!reset) begin
      case (state_r)
        S_GET_A: begin
          dp.readnum = rn_s;
          dp.loada   = 1'b1;
        end
        S_GET_B: begin
          dp.readnum = rm_s;
          dp.loadb   = 1'b1;
        end
        S_ALU: begin
          dp.loadc = 1'b1;
          dp.shift = sh_s;
          dp.asel  = is_mov_reg_s || is_mvn_s;
          dp.loads = is_alu_s;
          if (is_mov_reg_s) dp.ALUop = ALU_ADD;
          else              dp.ALUop = op_s;
        end
        S_WRITE_REG: begin
          dp.writenum = rd_s;
          dp.vsel     = VSEL_C;
          dp.write    = 1'b1;
        end
        S_WRITE_IMM: begin
          dp.writenum = rn_s;
          dp.vsel     = VSEL_IMM;
          dp.write    = 1'b1;
        end
        default: begin
          dp.write = 1'b0;
        end
      endcase
    end else begin
      dp.write = 1'b0;
    end
  end

endmodule

// File: tb/tb_simple_cpu_ctrl.sv
// Directed self-checking bench for simple_cpu_ctrl with hand-computed
// per-cycle expectations for each instruction class.
module tb_simple_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in = 16'h0000;
  logic        w;

  int errors = 0;
  int checks = 0;

  simple_cpu_ctrl_if dp ();

  simple_cpu_ctrl #(.IR_RESET(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .load  (load),
    .in    (in),
    .w     (w),
    .dp    (dp.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic any_strobe();
    return dp.write | dp.loada | dp.loadb | dp.loadc | dp.loads;
  endfunction

  // Load a word and pulse s together; returns in cycle 1 (DECODE)
  task automatic issue(input logic [15:0] word);
    in   = word;
    load = 1'b1;
    s    = 1'b1;
    tick();
    load = 1'b0;
    s    = 1'b0;
  endtask

  logic seen;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_w", {31'd0, w}, 32'd1);
    check("rst_strobes", {31'd0, any_strobe()}, 32'd0);
    check("rst_sximm8", {16'd0, dp.sximm8}, 32'h0000);
    check("rst_sel", {25'd0, dp.readnum, dp.vsel, dp.ALUop}, 32'd0);

    // MOV R0,#50
    issue(16'hD032);
    check("movi_c1_w", {31'd0, w}, 32'd0);
    check("movi_c1_write", {31'd0, dp.write}, 32'd0);
    tick();
    check("movi_c2_write", {31'd0, dp.write}, 32'd1);
    check("movi_c2_wnum", {29'd0, dp.writenum}, 32'd0);
    check("movi_c2_vsel", {30'd0, dp.vsel}, 32'd2);
    check("movi_c2_sx", {16'd0, dp.sximm8}, 32'h0032);
    check("movi_c2_imm5", {27'd0, dp.imm5}, 32'h12);
    tick();
    check("movi_c3_w", {31'd0, w}, 32'd1);
    check("movi_c3_write", {31'd0, dp.write}, 32'd0);

    // ADD R2,R0,R1
    issue(16'hA041);
    check("add_c1_w", {31'd0, w}, 32'd0);
    tick();
    check("add_c2_ga", {27'd0, dp.readnum, dp.loada, dp.loadb}, {27'd0, 3'd0, 1'b1, 1'b0});
    tick();
    check("add_c3_gb", {27'd0, dp.readnum, dp.loada, dp.loadb}, {27'd0, 3'd1, 1'b0, 1'b1});
    tick();
    check("add_c4_alu", {26'd0, dp.loadc, dp.loads, dp.ALUop, dp.asel, dp.bsel},
          {26'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0});
    check("add_c4_write", {31'd0, dp.write}, 32'd0);
    tick();
    check("add_c5_wr", {26'd0, dp.write, dp.writenum, dp.vsel}, {26'd0, 1'b1, 3'd2, 2'b00});
    check("add_c5_w", {31'd0, w}, 32'd0);
    tick();
    check("add_c6_w", {31'd0, w}, 32'd1);

    // CMP R0,R1
    issue(16'hA801);
    seen = dp.write;
    tick(); seen |= dp.write;
    tick(); seen |= dp.write;
    tick(); seen |= dp.write;
    check("cmp_c4_loads", {29'd0, dp.loads, dp.ALUop}, {29'd0, 1'b1, 2'b01});
    tick(); seen |= dp.write;
    check("cmp_c5_w", {31'd0, w}, 32'd1);
    check("cmp_nowrite", {31'd0, seen}, 32'd0);

    // MVN R7,R7
    issue(16'hB8E7);
    tick();
    check("mvn_c2_gb", {27'd0, dp.readnum, dp.loada, dp.loadb}, {27'd0, 3'd7, 1'b0, 1'b1});
    tick();
    check("mvn_c3_alu", {26'd0, dp.asel, dp.ALUop, dp.shift, dp.loads},
          {26'd0, 1'b1, 2'b11, 2'b00, 1'b1});
    tick();
    check("mvn_c4_wr", {28'd0, dp.write, dp.writenum}, {28'd0, 1'b1, 3'd7});
    tick();
    check("mvn_c5_w", {31'd0, w}, 32'd1);

    // MOV R3,R1,LSL#1
    issue(16'hC069);
    tick();
    check("movr_c2_gb", {27'd0, dp.readnum, dp.loada, dp.loadb}, {27'd0, 3'd1, 1'b0, 1'b1});
    tick();
    check("movr_c3_alu", {26'd0, dp.asel, dp.ALUop, dp.shift, dp.loads},
          {26'd0, 1'b1, 2'b00, 2'b01, 1'b0});
    tick();
    check("movr_c4_wr", {26'd0, dp.write, dp.writenum, dp.vsel}, {26'd0, 1'b1, 3'd3, 2'b00});
    tick();
    check("movr_c5_w", {31'd0, w}, 32'd1);

    // Load without start: negative immediate
    in = 16'hD0FF;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("sx_neg", {16'd0, dp.sximm8}, 32'h0000FFFF);
    check("imm5_max", {27'd0, dp.imm5}, 32'h1F);
    check("load_only_w", {31'd0, w}, 32'd1);

    // Illegal opcode
    issue(16'hE000);
    check("ill_c1_w", {31'd0, w}, 32'd0);
    seen = any_strobe();
    tick();
    seen |= any_strobe();
    check("ill_c2_w", {31'd0, w}, 32'd1);
    check("ill_nostrobe", {31'd0, seen}, 32'd0);

    // s/load while busy must not disturb the running ADD
    issue(16'hA041);
    tick();
    in = 16'hD032;
    load = 1'b1;
    s = 1'b1;
    tick();
    load = 1'b0;
    s = 1'b0;
    check("busy_c3_gb", {27'd0, dp.readnum, dp.loadb}, {27'd0, 3'd1, 1'b1});
    check("busy_ir", {16'd0, dp.sximm8}, 32'h0041);
    tick();
    tick();
    check("busy_c5_wr", {28'd0, dp.write, dp.writenum}, {28'd0, 1'b1, 3'd2});
    tick();
    check("busy_c6_w", {31'd0, w}, 32'd1);
    tick();
    check("busy_norestart", {30'd0, w, dp.loada}, {30'd0, 1'b1, 1'b0});

    // Reset during GET_B of an ADD
    issue(16'hA041);
    tick();
    tick();
    check("rstmid_gb", {31'd0, dp.loadb}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_same", {31'd0, any_strobe()}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rstmid_w", {31'd0, w}, 32'd1);
    check("rstmid_ir", {16'd0, dp.sximm8}, 32'h0000);
    seen = dp.write;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= dp.write;
    end
    check("rstmid_nowrite", {31'd0, seen}, 32'd0);
    check("rstmid_w_end", {31'd0, w}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
